// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Holds the EX stage through stallreq_for_ex until {remainder, quotient} is ready.
// Optional feature macro: DIV_SIGNED_EN (honor signed_div; unsigned-only otherwise).
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq_for_ex
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  localparam int              CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W+1:0]   diff;
  logic [2*DATA_W:0]   dividend_nx;
  logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Operand magnitudes; 0x80..0 maps to itself, which reads correctly as unsigned
  always_comb begin
    mag1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    mag2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
  end

  // Sign fix-up: quotient negative if signs differ, remainder follows dividend
  always_comb begin
    quo_fix = neg_q ? -quo : quo;
    rem_fix = neg_r ? -rem : rem;
  end
`else
  logic unused_signed_div;
  assign unused_signed_div = signed_div;

  // Unsigned-only build: operands and results pass straight through
  always_comb begin
    mag1    = opdata1;
    mag2    = opdata2;
    quo_fix = quo;
    rem_fix = rem;
  end
`endif

  // One restoring step. The partial remainder window can reach DATA_W+1 bits
  // (divisor above 2^(DATA_W-1)), so subtract one bit wider and use that MSB as borrow.
  always_comb begin
    diff = {1'b0, dividend[2*DATA_W:DATA_W]} - {2'b00, divisor};
    if (diff[DATA_W+1])
      dividend_nx = {dividend[2*DATA_W-1:0], 1'b0};
    else
      dividend_nx = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
    quo = dividend_nx[DATA_W-1:0];
    rem = dividend_nx[2*DATA_W:DATA_W+1];
  end

  assign stallreq_for_ex = start & ~ready & ~annul;

  // Control FSM plus datapath registers; annul beats everything except reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      result   <= '0;
      dividend <= '0;
      divisor  <= '0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else if (annul) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (opdata2 == '0) begin
            state <= DIVZERO;
          end else begin
            state    <= ON;
            cnt      <= '0;
            dividend <= {{DATA_W{1'b0}}, mag1, 1'b0};
            divisor  <= mag2;
`ifdef DIV_SIGNED_EN
            neg_q    <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r    <= signed_div & opdata1[DATA_W-1];
`endif
          end
        end
        DIVZERO: begin
          state  <= END;
          ready  <= 1'b1;
          result <= '0;
        end
        ON: begin
          dividend <= dividend_nx;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= END;
            ready  <= 1'b1;
            result <= {rem_fix, quo_fix};
          end
        end
        default: if (!start) begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with a cycle-level arithmetic model
// checked every cycle, plus literal expectations for latency and results.
module tb_div_seq;
  localparam int DATA_W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_for_ex;

  div_seq #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
    .result(result), .ready(ready), .stallreq_for_ex(stallreq_for_ex)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference arithmetic: plain integer division, truncating toward zero when signed
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (SGN && s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Cycle model: accepted divide finishes DATA_W cycles later (1 for a zero divisor)
  int          m_busy;
  logic        m_ready;
  logic [63:0] m_res, m_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_ready <= 1'b0; m_res <= '0; m_pend <= '0;
    end else if (annul) begin
      m_busy <= 0; m_ready <= 1'b0; m_res <= '0;
    end else if (m_ready) begin
      if (!start) m_ready <= 1'b0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_ready <= 1'b1;
        m_res   <= m_pend;
      end
    end else if (start) begin
      m_pend <= model(signed_div, opdata1, opdata2);
      m_busy <= (opdata2 == 32'd0) ? 1 : DATA_W;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc ready", {63'd0, ready}, {63'd0, m_ready});
      check("cyc result", result, m_res);
      check("cyc stall", {63'd0, stallreq_for_ex}, {63'd0, start & ~m_ready & ~annul});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Full handshake: start in cycle 0, expect ready at cycle lat, drop start, back to IDLE
  task automatic run_div(input string nm, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1;
    wait_ready(n);
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " result"}, result, exp);
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    // Model pinned against hand-computed values
    check("model 100/7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    check("model x/0", model(1'b0, 32'd5, 32'd0), 64'd0);
    check("model ffffffff/1", model(1'b0, 32'hFFFFFFFF, 32'd1), {32'd0, 32'hFFFFFFFF});

    // Reset state, with stall following start combinationally
    #1;
    check("reset ready", {63'd0, ready}, 64'd0);
    check("reset result", result, 64'd0);
    start = 1'b1;
    #1;
    check("reset stall", {63'd0, stallreq_for_ex}, 64'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
`ifdef DIV_SIGNED_EN
    run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    run_div("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
`else
    run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 33);
    run_div("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 33);
`endif
    run_div("div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
    run_div("uffffffff/1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);
    run_div("ubigdiv", 1'b0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1}, 33);
    run_div("unear", 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'd0}, 33);

    // Reset pulse mid-divide; start stays high so the divide restarts
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check("rst mid ready", {63'd0, ready}, 64'd0);
    check("rst mid result", result, 64'd0);
    check("rst mid stall", {63'd0, stallreq_for_ex}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    check("rst restart latency", 64'(n), 64'd33);
    check("rst restart result", result, {32'd1, 32'd333});
    tick();
    start = 1'b0;
    tick();

    // Annul in cycle 10: stall drops at once, IDLE next cycle, result cleared
    opdata1 = 32'd999; opdata2 = 32'd10; start = 1'b1;
    repeat (10) tick();
    annul = 1'b1;
    #1;
    check("annul stall", {63'd0, stallreq_for_ex}, 64'd0);
    tick();
    check("annul ready", {63'd0, ready}, 64'd0);
    check("annul result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    repeat (40) tick();
    check("annul no ready", {63'd0, ready}, 64'd0);

    // Back-to-back after the annul
    run_div("u999/10", 1'b0, 32'd999, 32'd10, {32'd9, 32'd99}, 33);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
